// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage with IF/ID pipeline register.
// Owns the PC, issues imem requests, handles stall/flush/redirect/halt.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_halt_req,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_imem_ready,
    output logic [31:0] o_if_id_pc,
    output logic [31:0] o_if_id_pc4,
    output logic [31:0] o_if_id_inst,
    output logic        o_if_id_valid,
    output logic        o_misalign_err,
    output logic        o_halted
);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_pc4;
    logic [31:0] r_if_inst;
    logic        r_if_valid;
    logic        r_misalign;
    logic        r_imem_req;
    logic        r_halted;

    state_t      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_if_pc_nxt;
    logic [31:0] w_if_pc4_nxt;
    logic [31:0] w_if_inst_nxt;
    logic        w_if_valid_nxt;
    logic        w_misalign_nxt;
    logic [31:0] w_pc4;

    assign w_pc4 = r_pc + 32'd4;

    // Next-state and next IF/ID contents, highest-priority event first
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_if_pc_nxt    = r_if_pc;
        w_if_pc4_nxt   = r_if_pc4;
        w_if_inst_nxt  = r_if_inst;
        w_if_valid_nxt = r_if_valid;
        w_misalign_nxt = 1'b0;
        case (r_state)
            ST_BOOT: begin
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (i_redirect_valid) begin
                    w_pc_nxt       = i_redirect_pc & ~32'h0000_0003;
                    w_if_pc_nxt    = r_pc;
                    w_if_pc4_nxt   = w_pc4;
                    w_if_inst_nxt  = NOP_INST;
                    w_if_valid_nxt = 1'b0;
                    w_misalign_nxt = (i_redirect_pc[1:0] != 2'b00);
                end else if (i_halt_req && !i_stall) begin
                    w_state_nxt    = ST_HALTED;
                    w_if_pc_nxt    = r_pc;
                    w_if_pc4_nxt   = w_pc4;
                    w_if_inst_nxt  = NOP_INST;
                    w_if_valid_nxt = 1'b0;
                end else if (i_stall) begin
                    // hold everything; the in-flight word is refetched later
                    w_pc_nxt = r_pc;
                end else if (i_flush) begin
                    w_if_pc_nxt    = r_pc;
                    w_if_pc4_nxt   = w_pc4;
                    w_if_inst_nxt  = NOP_INST;
                    w_if_valid_nxt = 1'b0;
                end else if (i_imem_ready) begin
                    w_pc_nxt       = w_pc4;
                    w_if_pc_nxt    = r_pc;
                    w_if_pc4_nxt   = w_pc4;
                    w_if_inst_nxt  = i_imem_rdata;
                    w_if_valid_nxt = 1'b1;
                end else begin
                    w_if_pc_nxt    = r_pc;
                    w_if_pc4_nxt   = w_pc4;
                    w_if_inst_nxt  = NOP_INST;
                    w_if_valid_nxt = 1'b0;
                end
            end
            ST_HALTED: begin
                w_state_nxt = ST_HALTED;
            end
            default: begin
                // illegal encoding: restart cleanly through BOOT with a bubble
                w_state_nxt    = ST_BOOT;
                w_pc_nxt       = RESET_PC;
                w_if_inst_nxt  = NOP_INST;
                w_if_valid_nxt = 1'b0;
            end
        endcase
    end

    // State, PC and IF/ID pipeline register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_BOOT;
            r_pc       <= RESET_PC;
            r_if_pc    <= 32'h0000_0000;
            r_if_pc4   <= 32'h0000_0000;
            r_if_inst  <= NOP_INST;
            r_if_valid <= 1'b0;
            r_misalign <= 1'b0;
            r_imem_req <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_if_pc    <= w_if_pc_nxt;
            r_if_pc4   <= w_if_pc4_nxt;
            r_if_inst  <= w_if_inst_nxt;
            r_if_valid <= w_if_valid_nxt;
            r_misalign <= w_misalign_nxt;
            r_imem_req <= (w_state_nxt == ST_RUN);
            r_halted   <= (w_state_nxt == ST_HALTED);
        end
    end

    assign o_imem_req     = r_imem_req;
    assign o_imem_addr    = r_pc;
    assign o_if_id_pc     = r_if_pc;
    assign o_if_id_pc4    = r_if_pc4;
    assign o_if_id_inst   = r_if_inst;
    assign o_if_id_valid  = r_if_valid;
    assign o_misalign_err = r_misalign;
    assign o_halted       = r_halted;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized
// traffic compared against a behavioural model of the fetch stage.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic [31:0] if_id_inst;
    logic        if_id_valid;
    logic        misalign_err;
    logic        halted;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // behavioural model
    logic [31:0] m_pc, m_ipc, m_ipc4, m_inst;
    logic        m_valid, m_mis, m_booting, m_halted;

    fetch_stage #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_stall         (stall),
        .i_flush         (flush),
        .i_redirect_valid(redirect_valid),
        .i_redirect_pc   (redirect_pc),
        .i_halt_req      (halt_req),
        .o_imem_req      (imem_req),
        .o_imem_addr     (imem_addr),
        .i_imem_rdata    (imem_rdata),
        .i_imem_ready    (imem_ready),
        .o_if_id_pc      (if_id_pc),
        .o_if_id_pc4     (if_id_pc4),
        .o_if_id_inst    (if_id_inst),
        .o_if_id_valid   (if_id_valid),
        .o_misalign_err  (misalign_err),
        .o_halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = RST_PC; m_ipc = 32'h0; m_ipc4 = 32'h0; m_inst = NOP;
        m_valid = 1'b0; m_mis = 1'b0; m_booting = 1'b1; m_halted = 1'b0;
    endtask

    task automatic model_bubble();
        m_ipc = m_pc; m_ipc4 = m_pc + 32'd4; m_inst = NOP; m_valid = 1'b0;
    endtask

    task automatic model_edge();
        m_mis = 1'b0;
        if (m_booting) begin
            m_booting = 1'b0;
        end else if (m_halted) begin
            m_halted = 1'b1;
        end else if (redirect_valid) begin
            model_bubble();
            m_mis = (redirect_pc % 4 != 0);
            m_pc  = redirect_pc - (redirect_pc % 4);
        end else if (halt_req && !stall) begin
            model_bubble();
            m_halted = 1'b1;
        end else if (stall) begin
            m_pc = m_pc;
        end else if (flush) begin
            model_bubble();
        end else if (imem_ready) begin
            m_ipc = m_pc; m_ipc4 = m_pc + 32'd4; m_inst = imem_rdata; m_valid = 1'b1;
            m_pc = m_pc + 32'd4;
        end else begin
            model_bubble();
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".addr"},  imem_addr, m_pc);
        check({tag, ".req"},   {31'd0, imem_req}, {31'd0, !m_booting && !m_halted});
        check({tag, ".pc"},    if_id_pc, m_ipc);
        check({tag, ".pc4"},   if_id_pc4, m_ipc4);
        check({tag, ".inst"},  if_id_inst, m_inst);
        check({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, m_valid});
        check({tag, ".mis"},   {31'd0, misalign_err}, {31'd0, m_mis});
        check({tag, ".halt"},  {31'd0, halted}, {31'd0, m_halted});
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    // pc-tagged instruction word for the current fetch address
    task automatic tag_rdata();
        imem_rdata = m_pc ^ 32'hA500_0000;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        #2;
        rst = 1'b0;
    endtask

    task automatic idle_inputs();
        stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 32'h0; halt_req = 1'b0; imem_ready = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        imem_rdata = 32'h0;
        model_reset();
        #12;
        check_all("reset");
        check("reset.inst_nop", if_id_inst, 32'h0000_0013);
        @(negedge clk);
        rst = 1'b0;

        // T1: boot then sequential fetch
        tag_rdata(); step("t1.boot");
        check("t1.boot_valid", {31'd0, if_id_valid}, 32'd0);
        tag_rdata(); step("t1.f0");
        check("t1.pc0", if_id_pc, 32'h0000_0000);
        tag_rdata(); step("t1.f4");
        check("t1.pc4", if_id_pc, 32'h0000_0004);
        check("t1.inst4", if_id_inst, 32'hA500_0004);

        // T2: stall three cycles at pc 0x8
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tag_rdata(); step("t2.stall");
            check("t2.addr_frozen", imem_addr, 32'h0000_0008);
            check("t2.pc_frozen", if_id_pc, 32'h0000_0004);
        end
        stall = 1'b0;
        tag_rdata(); step("t2.rel8");
        check("t2.pc8", if_id_pc, 32'h0000_0008);
        tag_rdata(); step("t2.relC");
        check("t2.pcC", if_id_pc, 32'h0000_000C);

        // T3: redirect overrides stall
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
        tag_rdata(); step("t3");
        check("t3.addr", imem_addr, 32'h0000_0100);
        check("t3.inst", if_id_inst, 32'h0000_0013);
        stall = 1'b0;

        // T4: misaligned redirect pulses misalign_err once
        redirect_pc = 32'h0000_0102;
        tag_rdata(); step("t4");
        check("t4.addr", imem_addr, 32'h0000_0100);
        check("t4.mis", {31'd0, misalign_err}, 32'd1);
        redirect_valid = 1'b0;
        tag_rdata(); step("t4.after");
        check("t4.mis_clr", {31'd0, misalign_err}, 32'd0);

        // T5: memory wait at pc 0x20
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0020;
        tag_rdata(); step("t5.redir");
        redirect_valid = 1'b0; imem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tag_rdata(); step("t5.wait");
            check("t5.addr_hold", imem_addr, 32'h0000_0020);
        end
        imem_ready = 1'b1;
        tag_rdata(); step("t5.load");
        check("t5.pc20", if_id_pc, 32'h0000_0020);
        check("t5.valid", {31'd0, if_id_valid}, 32'd1);

        // flush bubbles without moving pc
        flush = 1'b1;
        tag_rdata(); step("flush");
        check("flush.addr", imem_addr, 32'h0000_0024);
        flush = 1'b0;

        // pc+4 wraps at the top of the address space
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tag_rdata(); step("wrap.redir");
        redirect_valid = 1'b0;
        tag_rdata(); step("wrap.load");
        check("wrap.addr", imem_addr, 32'h0000_0000);
        check("wrap.pc4", if_id_pc4, 32'h0000_0000);

        // randomized traffic, with occasional halt and async reset
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                idle_inputs();
                do_reset("rnd.rst");
            end
            stall          = ($urandom_range(0, 3) == 0);
            flush          = ($urandom_range(0, 5) == 0);
            redirect_valid = ($urandom_range(0, 7) == 0);
            redirect_pc    = $urandom;
            halt_req       = ($urandom_range(0, 49) == 0);
            imem_ready     = ($urandom_range(0, 3) != 0);
            imem_rdata     = $urandom;
            step("rnd");
        end

        // T6: halt at pc 0x40, inputs ignored afterwards, reset recovers
        idle_inputs();
        do_reset("t6.rst0");
        tag_rdata(); step("t6.boot");
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
        tag_rdata(); step("t6.redir");
        redirect_valid = 1'b0; halt_req = 1'b1;
        tag_rdata(); step("t6.halt");
        for (int i = 0; i < 10; i++) begin
            stall = 1'($urandom); redirect_valid = 1'($urandom);
            redirect_pc = $urandom; imem_rdata = $urandom;
            step("t6.held");
            check("t6.halted", {31'd0, halted}, 32'd1);
            check("t6.req", {31'd0, imem_req}, 32'd0);
            check("t6.addr", imem_addr, 32'h0000_0040);
        end
        idle_inputs();
        do_reset("t6.rst");
        check("t6.rst_pc", imem_addr, RST_PC);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
